cmp_sched: RTL and testbench
============================

// Module: cmp_sched
// PURPOSE
//  Sequencer for the compare accelerator ALU (lshift/dshift/hscale/vscale units).
//  On a CPU request it loads the 1536-bit glyph bitmap from word memory and pulses the ALU start.
//  It then collects the four per-unit done flags, latches each unit's 16-bit result, and reports completion.
//  A WAIT-phase timeout reports a hung unit.
// PARAMETERS
//  BITMAP_W  1536  bitmap width in bits
//  WORD_W    16    memory word width; BITMAP_W % WORD_W == 0
//  NWORDS    BITMAP_W/WORD_W (96)  words per bitmap load
//  TIMEOUT   1024  max WAIT cycles before abort (>=2)
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset: synchronous, active-high
//  req            in   1     start a compare transaction; level, sampled in IDLE only
//  base_addr      in   16    first word address of bitmap; latched when req is accepted
//  busy           out  1     high in every state except IDLE
//  done           out  1     one-cycle completion pulse (normal or timeout)
//  timeout        out  1     sticky: last transaction aborted; cleared on next accept
//  done_mask      out  4     {vscale,hscale,dshift,lshift} units finished in last transaction
//  mem_rd         out  1     word read strobe
//  mem_addr       out  16    word read address
//  mem_rdata      in   16    read data, valid exactly 1 cycle after mem_rd
//  bitmap         out  1536  assembled bitmap to ALU; word k at bits [16k+15:16k]
//  alu_start      out  1     one-cycle ALU start pulse
//  alu_lshiftdone / alu_dshiftdone / alu_hscaledone / alu_vscaledone  in  1 each  per-unit done (level or pulse)
//  alu_lshift / alu_dshift / alu_hscale / alu_vscale                  in  16 each  per-unit results
//  res_lshift / res_dshift / res_hscale / res_vscale                  out 16 each  latched results
// BEHAVIOUR
//  Reset: every output and internal register is 0; FSM goes to IDLE; bitmap cleared.
//  - Applies on any cycle, including mid-LOAD/WAIT; an in-flight read return is discarded.
//  FSM: IDLE -> LOAD -> DRAIN -> START -> WAIT -> DONE -> IDLE.
//  - IDLE: if req=1, latch base_addr; clear res_*, done_mask, timeout, word counter; go to LOAD.
//  - LOAD: mem_rd=1, mem_addr=base+cnt (16-bit modular, 0xFFFF wraps to 0x0000), cnt++.
//    After cnt=NWORDS-1 is issued, go to DRAIN.
//  - Read return each cycle after mem_rd: bitmap[16*k +: 16] <= mem_rdata, k = cnt of that read.
//  - DRAIN: capture the last word, no read; go to START.
//  - START: alu_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
//    Done flags are not sampled in START.
//  - WAIT: each cycle, for each unit whose flag=1 and mask bit=0:
//    set its mask bit and latch alu_<unit> into res_<unit>.
//    Later flag/result changes are ignored (first-seen value is held).
//    Mask complete (including bits set this cycle) -> DONE.
//    Else if timeout counter == TIMEOUT-1 -> set timeout=1, go to DONE.
//    Else counter++.
//  - DONE: done=1 for one cycle; go to IDLE. res_*, done_mask, timeout hold until the next accept.
//  Latency, req accepted at cycle 0:
//  - mem_rd at cycles 1..96; last word captured at 97; alu_start at 98; WAIT from 99.
//  - All flags first seen at cycle N -> done=1 at N+1.
//  Simultaneous flags: all latched in the same cycle.
//  Timeout: unfinished units keep res=0 and mask bit=0.
//  req while busy: ignored, no queueing.
//  req held high: next transaction accepted on the IDLE cycle after DONE.
//  bitmap holds its value between transactions.
// TESTING
//  1 base=0x0100, mem[a]=a-0x0100; all four flags at cycle 110, results 1,2,3,4:
//    mem_addr 0x0100..0x015F; bitmap[15:0]=0, bitmap[1535:1520]=0x005F; alu_start at 98;
//    done at 111; res=1,2,3,4; done_mask=4'hF; timeout=0.
//  2 Flags at 100/105/120/130, each result changes 1 cycle after its flag:
//    first-seen values held; done at 131.
//  3 TIMEOUT=16, vscale never done: done 16 WAIT cycles after entry; timeout=1;
//    done_mask=4'b0111; res_vscale=0.
//  4 base=0xFFF0: addresses 0xFFF0..0xFFFF then 0x0000..0x004F; 96 reads total.
//  5 rst at cycle 50 (mid-LOAD): next cycle busy=0, mem_rd=0, bitmap=0, all outputs 0;
//    a fresh req completes as in test 1.
//  6 req held high throughout: a second pulse during WAIT has no effect;
//    next accept occurs the cycle after done; outputs cleared at accept.

Source files
------------

// File: rtl/cmp_sched.sv
// Compare-accelerator sequencer. It loads the glyph bitmap word by word and pulses the ALU start.
// It then collects the four per-unit done flags and results, with a watchdog for a hung unit.
module cmp_sched #(
  parameter int BITMAP_W = 1536,
  parameter int WORD_W   = 16,
  parameter int NWORDS   = BITMAP_W / WORD_W,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [15:0]         base_addr,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [3:0]          done_mask,
  output logic                mem_rd,
  output logic [15:0]         mem_addr,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic [BITMAP_W-1:0] bitmap,
  output logic                alu_start,
  input  logic                alu_lshiftdone,
  input  logic                alu_dshiftdone,
  input  logic                alu_hscaledone,
  input  logic                alu_vscaledone,
  input  logic [15:0]         alu_lshift,
  input  logic [15:0]         alu_dshift,
  input  logic [15:0]         alu_hscale,
  input  logic [15:0]         alu_vscale,
  output logic [15:0]         res_lshift,
  output logic [15:0]         res_dshift,
  output logic [15:0]         res_hscale,
  output logic [15:0]         res_vscale
);

  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_START, S_WAIT, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_base;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rd_pend;
  logic [CNT_W-1:0]    r_rd_idx;
  logic [BITMAP_W-1:0] r_bitmap;
  logic [TO_W-1:0]     r_tcnt;
  logic [3:0]          r_mask;
  logic                r_timeout;
  logic [3:0][15:0]    r_res;

  logic [3:0]          w_flags;
  logic [3:0][15:0]    w_alu;
  logic [3:0]          w_hit;
  logic [3:0]          w_mask_new;
  logic                w_complete;
  logic                w_last_word;
  logic                w_expired;

  // Unit order everywhere is {vscale, hscale, dshift, lshift}.
  assign w_flags     = {alu_vscaledone, alu_hscaledone, alu_dshiftdone, alu_lshiftdone};
  assign w_alu       = {alu_vscale, alu_hscale, alu_dshift, alu_lshift};
  assign w_hit       = w_flags & ~r_mask;
  assign w_mask_new  = r_mask | w_flags;
  assign w_complete  = &w_mask_new;
  assign w_last_word = (r_cnt == CNT_W'(NWORDS - 1));
  assign w_expired   = (r_tcnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req) w_next = S_LOAD;
      S_LOAD:  if (w_last_word) w_next = S_DRAIN;
      S_DRAIN: w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (w_complete || w_expired) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    mem_rd    = (r_state == S_LOAD);
    mem_addr  = (r_state == S_LOAD) ? (r_base + 16'(r_cnt)) : 16'h0000;
    alu_start = (r_state == S_START);
    done      = (r_state == S_DONE);
  end

  // Read data arrives one cycle after the strobe, so the word index travels with a pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base    <= '0;
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_idx  <= '0;
      r_bitmap  <= '0;
      r_tcnt    <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
      r_res     <= '0;
    end else begin
      r_rd_pend <= (r_state == S_LOAD);
      r_rd_idx  <= r_cnt;
      if (r_rd_pend) begin
        for (int k = 0; k < NWORDS; k++) begin
          if (r_rd_idx == CNT_W'(k)) r_bitmap[k*WORD_W +: WORD_W] <= mem_rdata;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_base    <= base_addr;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_timeout <= 1'b0;
            r_res     <= '0;
          end
        end
        S_LOAD:  r_cnt  <= r_cnt + CNT_W'(1);
        S_START: r_tcnt <= '0;
        S_WAIT: begin
          r_mask <= w_mask_new;
          for (int u = 0; u < 4; u++) begin
            if (w_hit[u]) r_res[u] <= w_alu[u];
          end
          if (!w_complete) begin
            if (w_expired) r_timeout <= 1'b1;
            else           r_tcnt    <= r_tcnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bitmap     = r_bitmap;
  assign done_mask  = r_mask;
  assign timeout    = r_timeout;
  assign res_lshift = r_res[0];
  assign res_dshift = r_res[1];
  assign res_hscale = r_res[2];
  assign res_vscale = r_res[3];

endmodule

// File: tb/tb_cmp_sched.sv
// Bench for cmp_sched: directed and random transactions against a cycle-window reference model.
// Cycle c of a transaction is the c-th clock period after the edge that accepted req.
module tb_cmp_sched;
  localparam int TO = 32;
  localparam int NW = 96;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [15:0]  base_addr = 16'h0;
  logic         busy, done, timeout, mem_rd, alu_start;
  logic [3:0]   done_mask;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_rdata = 16'h0;
  logic [1535:0] bitmap;
  logic         alu_lshiftdone = 0, alu_dshiftdone = 0, alu_hscaledone = 0, alu_vscaledone = 0;
  logic [15:0]  alu_lshift = 0, alu_dshift = 0, alu_hscale = 0, alu_vscale = 0;
  logic [15:0]  res_lshift, res_dshift, res_hscale, res_vscale;

  cmp_sched #(.BITMAP_W(1536), .WORD_W(16), .NWORDS(NW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .base_addr(base_addr),
    .busy(busy), .done(done), .timeout(timeout), .done_mask(done_mask),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .bitmap(bitmap), .alu_start(alu_start),
    .alu_lshiftdone(alu_lshiftdone), .alu_dshiftdone(alu_dshiftdone),
    .alu_hscaledone(alu_hscaledone), .alu_vscaledone(alu_vscaledone),
    .alu_lshift(alu_lshift), .alu_dshift(alu_dshift),
    .alu_hscale(alu_hscale), .alu_vscale(alu_vscale),
    .res_lshift(res_lshift), .res_dshift(res_dshift),
    .res_hscale(res_hscale), .res_vscale(res_vscale)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];

  // Word memory: data valid the cycle after the strobe, garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 16'($urandom);

  int n_checks = 0;
  int n_pass   = 0;

  int          f_at [4];
  bit          f_pulse;
  bit          f_chg;
  logic [15:0] r_val [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic flag_at(input int i, input int c);
    if (f_at[i] == 0) return 1'b0;
    return f_pulse ? (c == f_at[i]) : (c >= f_at[i]);
  endfunction

  // With f_chg set, a unit's result changes one cycle after its flag rises.
  function automatic logic [15:0] alu_at(input int i, input int c);
    return (f_chg && f_at[i] != 0 && c > f_at[i]) ? (r_val[i] ^ 16'h5A5A) : r_val[i];
  endfunction

  task automatic drive_alu(input int c);
    alu_lshiftdone = flag_at(0, c);
    alu_dshiftdone = flag_at(1, c);
    alu_hscaledone = flag_at(2, c);
    alu_vscaledone = flag_at(3, c);
    alu_lshift = alu_at(0, c);
    alu_dshift = alu_at(1, c);
    alu_hscale = alu_at(2, c);
    alu_vscale = alu_at(3, c);
  endtask

  task automatic set_cfg(input int a, input int b, input int c, input int d,
                         input bit pulse, input bit chg,
                         input logic [15:0] ra, input logic [15:0] rb,
                         input logic [15:0] rc, input logic [15:0] rd);
    f_at[0] = a; f_at[1] = b; f_at[2] = c; f_at[3] = d;
    f_pulse = pulse; f_chg = chg;
    r_val[0] = ra; r_val[1] = rb; r_val[2] = rc; r_val[3] = rd;
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < 4; i++) begin
      f_at[i]  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(90, 99 + TO + 3));
      r_val[i] = 16'($urandom);
    end
    f_pulse = 1'($urandom);
    f_chg   = 1'($urandom);
  endtask

  // One transaction, starting in an IDLE cycle (cycle 0) and ending in the IDLE cycle after done.
  task automatic run_txn(input logic [15:0] base, input bit hold, input bit keep,
                         input int req_pulse_at, output int obs_done);
    int seen [4];
    int term, exp_done, rd_err, ctl_err, n_rd, bm_err;
    bit exp_to;
    logic [3:0]  exp_mask;
    logic [15:0] exp_res [4];
    logic [15:0] a;

    // Reference: scan the WAIT window for the first cycle each unit's flag is high.
    for (int i = 0; i < 4; i++) seen[i] = -1;
    term = -1;
    for (int c = 99; c <= 99 + TO - 1 && term < 0; c++) begin
      for (int i = 0; i < 4; i++) if (seen[i] < 0 && flag_at(i, c)) seen[i] = c;
      if (seen[0] >= 0 && seen[1] >= 0 && seen[2] >= 0 && seen[3] >= 0) term = c;
    end
    exp_to   = (term < 0);
    exp_done = exp_to ? (99 + TO) : (term + 1);
    for (int i = 0; i < 4; i++) begin
      exp_mask[i] = (seen[i] >= 0);
      exp_res[i]  = (seen[i] >= 0) ? alu_at(i, seen[i]) : 16'h0;
    end

    base_addr = base;
    req = 1'b1;
    drive_alu(0);
    step();
    rd_err = 0; ctl_err = 0; n_rd = 0; obs_done = -1;
    chk("clr_mask", 32'(done_mask), 32'h0);
    chk("clr_timeout", 32'(timeout), 32'h0);
    chk("clr_res", 32'(res_lshift | res_dshift | res_hscale | res_vscale), 32'h0);
    for (int c = 1; c <= exp_done; c++) begin
      req = hold ? 1'b1 : (c == req_pulse_at);
      base_addr = 16'($urandom);
      drive_alu(c);
      if (mem_rd !== (c <= NW)) rd_err++;
      if (mem_rd === 1'b1) begin
        n_rd++;
        if (mem_addr !== base + 16'(c - 1)) rd_err++;
      end
      if (alu_start !== (c == 98)) ctl_err++;
      if (busy !== 1'b1) ctl_err++;
      if (done !== (c == exp_done)) ctl_err++;
      if (done === 1'b1 && obs_done < 0) obs_done = c;
      if (c == exp_done) req = keep;
      else step();
    end
    chk("done_cycle", 32'(obs_done), 32'(exp_done));
    chk("read_seq_errs", 32'(rd_err), 32'h0);
    chk("read_count", 32'(n_rd), 32'(NW));
    chk("ctl_errs", 32'(ctl_err), 32'h0);
    chk("timeout", 32'(timeout), 32'(exp_to));
    chk("done_mask", 32'(done_mask), 32'(exp_mask));
    chk("res_lshift", 32'(res_lshift), 32'(exp_res[0]));
    chk("res_dshift", 32'(res_dshift), 32'(exp_res[1]));
    chk("res_hscale", 32'(res_hscale), 32'(exp_res[2]));
    chk("res_vscale", 32'(res_vscale), 32'(exp_res[3]));
    bm_err = 0;
    for (int k = 0; k < NW; k++) begin
      a = base + 16'(k);
      if (bitmap[16*k +: 16] !== mem[a]) bm_err++;
    end
    chk("bitmap_word_errs", 32'(bm_err), 32'h0);
    step();
    chk("idle_busy_done", 32'({busy, done}), 32'h0);
    chk("idle_hold_mask", 32'(done_mask), 32'(exp_mask));
    $display("txn base=%h flags=%0d/%0d/%0d/%0d pulse=%0d done@%0d timeout=%0d mask=%b",
             base, f_at[0], f_at[1], f_at[2], f_at[3], f_pulse, obs_done, timeout, done_mask);
  endtask

  initial begin
    int d;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) - 16'h0100;
    set_cfg(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    drive_alu(0);

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_ctl", 32'({busy, done, timeout, mem_rd, alu_start}), 32'h0);
    chk("rst_mask_addr", 32'({done_mask, mem_addr}), 32'h0);
    chk("rst_bitmap", 32'(|bitmap), 32'h0);

    // 1: base 0x0100, all flags at 110, results 1..4
    set_cfg(110, 110, 110, 110, 0, 0, 16'd1, 16'd2, 16'd3, 16'd4);
    run_txn(16'h0100, 0, 0, 0, d);
    chk("t1_done_at_111", 32'(d), 32'd111);
    chk("t1_bitmap_lo", 32'(bitmap[15:0]), 32'h0000);
    chk("t1_bitmap_hi", 32'(bitmap[1535:1520]), 32'h005F);
    chk("t1_res", {res_lshift[7:0], res_dshift[7:0], res_hscale[7:0], res_vscale[7:0]}, 32'h01020304);

    // 2: staggered flags, results change after each flag; last flag hits the final WAIT cycle
    set_cfg(100, 105, 120, 130, 0, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    run_txn(16'h0200, 0, 0, 0, d);
    chk("t2_done_at_131", 32'(d), 32'd131);
    chk("t2_first_seen", 32'({res_lshift, res_vscale}), 32'h11114444);

    // 3: vscale never finishes, with a stray req pulse during WAIT
    set_cfg(100, 101, 110, 0, 0, 0, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
    run_txn(16'h0300, 0, 0, 105, d);
    chk("t3_done_at_timeout", 32'(d), 32'(99 + TO));
    chk("t3_timeout_mask", 32'({timeout, done_mask}), 32'h17);
    chk("t3_busy_after", 32'(busy), 32'h0);

    // 4: address wrap at 0xFFFF, random memory contents and flags
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    rand_cfg();
    run_txn(16'hFFF0, 0, 0, 0, d);

    // 5: reset in the middle of LOAD, then a fresh transaction
    base_addr = 16'h0100;
    req = 1'b1;
    step();
    req = 1'b0;
    repeat (49) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ctl", 32'({busy, done, timeout, mem_rd, alu_start}), 32'h0);
    chk("mid_rst_outs", 32'({done_mask, mem_addr}), 32'h0);
    chk("mid_rst_res", 32'(res_lshift | res_dshift | res_hscale | res_vscale), 32'h0);
    chk("mid_rst_bitmap", 32'(|bitmap), 32'h0);
    step();
    chk("mid_rst_inflight_dropped", 32'(|bitmap), 32'h0);
    chk("mid_rst_idle", 32'(busy), 32'h0);
    set_cfg(110, 110, 110, 110, 0, 0, 16'd1, 16'd2, 16'd3, 16'd4);
    run_txn(16'h0100, 0, 0, 0, d);
    chk("t5_done_at_111", 32'(d), 32'd111);

    // 6: req held high across back-to-back transactions; first one times out
    set_cfg(99, 0, 120, 104, 0, 0, 16'hBEEF, 16'hCAFE, 16'h1234, 16'h5678);
    run_txn(16'h4000, 1, 1, 0, d);
    rand_cfg();
    run_txn(16'h8000, 1, 0, 0, d);

    // 7: random transactions
    for (int t = 0; t < 4; t++) begin
      rand_cfg();
      run_txn(16'($urandom), 0, 0, int'($urandom_range(99, 120)), d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
